// File: rtl/project_period_counter_master.sv
// project_period_counter_master: PWM master timebase with up/down/up-down counting,
// a shadowed period register, a boundary-divided sync strobe and a forced restart.
`default_nettype none

module project_period_counter_master #(
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic [1:0]           i_mode,
    input  logic [WIDTH-1:0]     i_period,
    input  logic                 i_sync_en,
    input  logic [DIV_WIDTH-1:0] i_sync_div,
    input  logic                 i_sync_force,
    output logic [WIDTH-1:0]     o_period,
    output logic [WIDTH-1:0]     o_period_next,
    output logic                 o_dir,
    output logic                 o_boundary,
    output logic                 o_sync
);

    localparam logic [1:0]           MODE_UP   = 2'b01;
    localparam logic [1:0]           MODE_DOWN = 2'b10;
    localparam logic [WIDTH-1:0]     ONE       = WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    logic [WIDTH-1:0]     count;
    logic [WIDTH-1:0]     shadow;
    logic [WIDTH-1:0]     count_nxt;
    logic                 dir;
    logic                 dir_nxt;
    logic                 bnd_nxt;
    logic                 boundary;
    logic                 sync;
    logic [DIV_WIDTH-1:0] sync_cnt;
    logic                 active;
    logic                 force_down;

    assign active     = i_en && (i_mode != 2'b00);
    assign force_down = (i_mode == MODE_DOWN);

    // Next count always uses the current shadow; only a down reload takes the new period.
    always_comb begin
        count_nxt = count;
        dir_nxt   = dir;
        bnd_nxt   = 1'b0;
        if (active) begin
            if (shadow == '0) begin
                count_nxt = '0;
                dir_nxt   = 1'b1;
                bnd_nxt   = 1'b1;
            end else begin
                case (i_mode)
                    MODE_UP: begin
                        dir_nxt = 1'b1;
                        if (count >= shadow) begin
                            count_nxt = '0;
                            bnd_nxt   = 1'b1;
                        end else begin
                            count_nxt = count + ONE;
                        end
                    end
                    MODE_DOWN: begin
                        dir_nxt = 1'b0;
                        if (count == '0) begin
                            count_nxt = i_period;
                            bnd_nxt   = 1'b1;
                        end else begin
                            count_nxt = count - ONE;
                        end
                    end
                    default: begin
                        if (dir) begin
                            if (count >= shadow) begin
                                count_nxt = shadow - ONE;
                                dir_nxt   = 1'b0;
                            end else begin
                                count_nxt = count + ONE;
                            end
                        end else begin
                            if (count == '0) begin
                                count_nxt = ONE;
                                dir_nxt   = 1'b1;
                            end else begin
                                count_nxt = count - ONE;
                            end
                        end
                        bnd_nxt = (count_nxt == '0) && (count != '0);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count    <= '0;
            dir      <= 1'b1;
            boundary <= 1'b0;
            sync     <= 1'b0;
            sync_cnt <= '0;
            shadow   <= i_period;
        end else if (i_sync_force) begin
            shadow   <= i_period;
            count    <= force_down ? i_period : '0;
            dir      <= !(force_down && (i_period != '0));
            sync_cnt <= '0;
            boundary <= 1'b1;
            sync     <= i_sync_en;
        end else begin
            count    <= count_nxt;
            dir      <= dir_nxt;
            boundary <= bnd_nxt;
            sync     <= 1'b0;
            if (bnd_nxt) begin
                shadow <= i_period;
            end
            if (!i_sync_en) begin
                sync_cnt <= '0;
            end else if (bnd_nxt) begin
                // A counter above the divider wraps around and matches again later.
                if (sync_cnt == i_sync_div) begin
                    sync     <= 1'b1;
                    sync_cnt <= '0;
                end else begin
                    sync_cnt <= sync_cnt + DIV_ONE;
                end
            end
        end
    end

    assign o_period      = count;
    assign o_period_next = count_nxt;
    assign o_dir         = dir;
    assign o_boundary    = boundary;
    assign o_sync        = sync;

endmodule

`default_nettype wire
